hazard_unit: RTL and testbench

- Pipeline-control counterpart to the EX-stage forwarding logic. Forwarding consumes producer destinations and selects operands; this block handles the hazards forwarding cannot resolve: load-use, taken branch/jump, I/D-memory wait, halt.
- Produces per-latch enables/flushes and the PC enable for the 5-stage datapath.
- Keeps a small FSM for multi-cycle conditions and saturating perf counters.

---
 rtl/hazard_unit_pkg.sv | 29 ++
 rtl/hazard_unit_if.sv | 43 ++++
 rtl/hazard_unit_sat_counter.sv | 29 ++
 rtl/hazard_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
//   Shared types for the pipeline hazard controller.
//   regbits_t   : 5-bit architectural register index
//   hazstate_t  : controller state (RUN, DISCARD, HALT)
//   isLoadUse() : load-use detection between the EX load and the ID sources
package hazard_unit_pkg;

  typedef logic [4:0] regbits_t;

  localparam regbits_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DISCARD = 2'd1,
    HALT    = 2'd2
  } hazstate_t;

  // A load in EX whose destination feeds the instruction in ID cannot be
  // forwarded in time. Register $0 is hardwired, so it never creates a hazard.
  function automatic logic isLoadUse(input logic     memRead,
                                     input regbits_t dest,
                                     input regbits_t rs,
                                     input regbits_t rt,
                                     input logic     useRt);
    return memRead && (dest != REG_ZERO) &&
           ((dest == rs) || (useRt && (dest == rt)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if
//   Bundle of all hazard-unit signals, following the unit-interface pattern.
//   modport hu : view from the hazard unit (hazard inputs in, controls out)
//   modport tb : view from a driver/checker (hazard inputs out, controls in)
interface hazard_unit_if #(parameter int CNT_W = 16);

  logic [4:0]       rsID;
  logic [4:0]       rtID;
  logic             useRtID;
  logic [4:0]       destEX;
  logic             memReadEX;
  logic             takenEX;
  logic             ihit;
  logic             dreqMEM;
  logic             dhit;
  logic             haltWB;
  logic             pcEn;
  logic             enIFID;
  logic             enIDEX;
  logic             enEXMEM;
  logic             enMEMWB;
  logic             flushIFID;
  logic             flushIDEX;
  logic             flushEXMEM;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport hu (
    input  rsID, rtID, useRtID, destEX, memReadEX, takenEX,
           ihit, dreqMEM, dhit, haltWB,
    output pcEn, enIFID, enIDEX, enEXMEM, enMEMWB,
           flushIFID, flushIDEX, flushEXMEM, halted, stall_cnt, flush_cnt
  );

  modport tb (
    output rsID, rtID, useRtID, destEX, memReadEX, takenEX,
           ihit, dreqMEM, dhit, haltWB,
    input  pcEn, enIFID, enIDEX, enEXMEM, enMEMWB,
           flushIFID, flushIDEX, flushEXMEM, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter
//   Event counter that sticks at its maximum instead of wrapping.
//   CLK  : clock
//   nRST : asynchronous active-low reset, clears the count
//   inc  : count this cycle
//   cnt  : current count, W bits
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  // Count requested events; once all ones, hold so the value never wraps
  // back to a misleadingly small number.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Pipeline control for the hazards forwarding cannot resolve: load-use,
//   taken branch/jump, instruction/data memory wait and halt.
//   Inputs : CLK, nRST (async active-low), rsID/rtID/useRtID (ID sources),
//            destEX/memReadEX (EX producer), takenEX, ihit, dreqMEM, dhit,
//            haltWB
//   Outputs: pcEn, enIFID/enIDEX/enEXMEM/enMEMWB (latch enables),
//            flushIFID/flushIDEX/flushEXMEM (synchronous bubbles), halted,
//            stall_cnt/flush_cnt (saturating perf counters, CNT_W bits)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       rsID,
  input  logic [4:0]       rtID,
  input  logic             useRtID,
  input  logic [4:0]       destEX,
  input  logic             memReadEX,
  input  logic             takenEX,
  input  logic             ihit,
  input  logic             dreqMEM,
  input  logic             dhit,
  input  logic             haltWB,
  output logic             pcEn,
  output logic             enIFID,
  output logic             enIDEX,
  output logic             enEXMEM,
  output logic             enMEMWB,
  output logic             flushIFID,
  output logic             flushIDEX,
  output logic             flushEXMEM,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazstate_t state;
  hazstate_t nextState;
  logic      loadUse;
  logic      dataWait;
  logic      freeze;
  logic      stallInc;
  logic      flushInc;

  // Hazard terms. A halt reaching WB freezes the pipe for its last cycle
  // exactly like an outstanding data access does.
  always_comb begin
    loadUse  = isLoadUse(memReadEX, destEX, rsID, rtID, useRtID);
    dataWait = dreqMEM & ~dhit;
    freeze   = haltWB | dataWait;
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Next state. A freeze holds the state, so a pending DISCARD survives a
  // data wait. A taken branch with a missed fetch leaves a wrong-path fetch
  // in flight that must be dropped when it finally arrives.
  always_comb begin
    nextState = state;
    case (state)
      HALT: begin
        nextState = HALT;
      end
      RUN, DISCARD: begin
        if (haltWB) begin
          nextState = HALT;
        end else if (dataWait) begin
          nextState = state;
        end else if (takenEX) begin
          nextState = ihit ? RUN : DISCARD;
        end else if ((state == DISCARD) && ihit) begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

  // Outputs. Priority: HALT state, freeze, taken branch, load-use, fetch miss.
  // While discarding, IF/ID is flushed every cycle on top of whatever the
  // lower-priority rules decide, which also drops the wrong-path word on the
  // cycle it arrives.
  always_comb begin
    pcEn       = 1'b1;
    enIFID     = 1'b1;
    enIDEX     = 1'b1;
    enEXMEM    = 1'b1;
    enMEMWB    = 1'b1;
    flushIFID  = 1'b0;
    flushIDEX  = 1'b0;
    flushEXMEM = 1'b0;
    halted     = 1'b0;
    if (state == HALT) begin
      pcEn    = 1'b0;
      enIFID  = 1'b0;
      enIDEX  = 1'b0;
      enEXMEM = 1'b0;
      enMEMWB = 1'b0;
      halted  = 1'b1;
    end else if (freeze) begin
      pcEn    = 1'b0;
      enIFID  = 1'b0;
      enIDEX  = 1'b0;
      enEXMEM = 1'b0;
      enMEMWB = 1'b0;
    end else if (takenEX) begin
      flushIFID = 1'b1;
      flushIDEX = 1'b1;
    end else begin
      if (loadUse) begin
        pcEn      = 1'b0;
        enIFID    = 1'b0;
        flushIDEX = 1'b1;
      end else if (!ihit) begin
        pcEn      = 1'b0;
        flushIFID = 1'b1;
      end
      if (state == DISCARD) begin
        flushIFID = 1'b1;
      end
    end
  end

  // Counter events. Nothing counts once halted; flushes are already zero there.
  always_comb begin
    stallInc = ~pcEn & (state != HALT);
    flushInc = flushIFID | flushIDEX | flushEXMEM;
  end

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stallInc),
    .cnt  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flushInc),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//   Directed self-checking bench for hazard_unit with a 4-bit counter width
//   so saturation is reachable in a few cycles.
module tb_hazard_unit;

  localparam int CW = 4;

  // Packed control view: {pcEn, enIFID, enIDEX, enEXMEM, enMEMWB,
  //                       flushIFID, flushIDEX, flushEXMEM, halted}
  localparam logic [8:0] C_RUN    = 9'b1_1111_000_0;
  localparam logic [8:0] C_LDUSE  = 9'b0_0111_010_0;
  localparam logic [8:0] C_FREEZE = 9'b0_0000_000_0;
  localparam logic [8:0] C_TAKEN  = 9'b1_1111_110_0;
  localparam logic [8:0] C_MISS   = 9'b0_1111_100_0;
  localparam logic [8:0] C_DHIT   = 9'b1_1111_100_0;
  localparam logic [8:0] C_HALT   = 9'b0_0000_000_1;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  hazard_unit_if #(.CNT_W(CW)) hif ();

  hazard_unit #(.CNT_W(CW)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .rsID       (hif.rsID),
    .rtID       (hif.rtID),
    .useRtID    (hif.useRtID),
    .destEX     (hif.destEX),
    .memReadEX  (hif.memReadEX),
    .takenEX    (hif.takenEX),
    .ihit       (hif.ihit),
    .dreqMEM    (hif.dreqMEM),
    .dhit       (hif.dhit),
    .haltWB     (hif.haltWB),
    .pcEn       (hif.pcEn),
    .enIFID     (hif.enIFID),
    .enIDEX     (hif.enIDEX),
    .enEXMEM    (hif.enEXMEM),
    .enMEMWB    (hif.enMEMWB),
    .flushIFID  (hif.flushIFID),
    .flushIDEX  (hif.flushIDEX),
    .flushEXMEM (hif.flushEXMEM),
    .halted     (hif.halted),
    .stall_cnt  (hif.stall_cnt),
    .flush_cnt  (hif.flush_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic useRt, input logic [4:0] dest,
                               input logic memRead, input logic taken,
                               input logic ih, input logic dreq,
                               input logic dh, input logic halt);
    hif.rsID      = rs;
    hif.rtID      = rt;
    hif.useRtID   = useRt;
    hif.destEX    = dest;
    hif.memReadEX = memRead;
    hif.takenEX   = taken;
    hif.ihit      = ih;
    hif.dreqMEM   = dreq;
    hif.dhit      = dh;
    hif.haltWB    = halt;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkControl(input string tag, input logic [8:0] expected);
    logic [8:0] observed;
    observed = {hif.pcEn, hif.enIFID, hif.enIDEX, hif.enEXMEM, hif.enMEMWB,
                hif.flushIFID, hif.flushIDEX, hif.flushEXMEM, hif.halted};
    checkOutput(tag, {7'd0, observed}, {7'd0, expected});
  endtask

  task automatic checkCounters(input string tag, input int stallExp,
                               input int flushExp);
    checkOutput({tag, "_stall"}, {12'd0, hif.stall_cnt}, 16'(stallExp));
    checkOutput({tag, "_flush"}, {12'd0, hif.flush_cnt}, 16'(flushExp));
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    idle();
    nRST = 1'b0;
    advance();
    nRST = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    idle();
    #1;
    checkControl("reset_ctl", C_RUN);
    checkCounters("reset", 0, 0);
    advance();
    nRST = 1'b1;

    // Normal flow: no hazards, fetch hitting.
    for (int i = 0; i < 5; i++) begin
      idle();
      #1;
      checkControl("normal_ctl", C_RUN);
      advance();
    end
    checkCounters("normal", 0, 0);

    // Load-use on rs: one bubble, then EX holds the bubble.
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkControl("lduse_rs", C_LDUSE);
    advance();
    idle();
    #1;
    checkControl("lduse_clear", C_RUN);
    checkCounters("lduse", 1, 1);
    advance();
    // $0 destination never stalls.
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkControl("lduse_r0", C_RUN);
    advance();
    // rt match ignored when the instruction does not read rt.
    applyStimulus(5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkControl("lduse_rt_unused", C_RUN);
    advance();
    // Same rt match with rt read does stall.
    applyStimulus(5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkControl("lduse_rt_used", C_LDUSE);
    advance();
    checkCounters("lduse_end", 2, 2);

    // Taken branch with a fetch miss, two more misses, then the hit.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkControl("taken_miss", C_TAKEN);
    advance();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkControl("discard_miss", C_MISS);
      advance();
    end
    idle();
    #1;
    checkControl("discard_hit", C_DHIT);
    advance();
    idle();
    #1;
    checkControl("discard_back_run", C_RUN);
    checkCounters("discard", 2, 4);
    advance();

    // A data wait in the middle of DISCARD must not lose the discard.
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkControl("taken_miss2", C_TAKEN);
    advance();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkControl("discard_dwait", C_FREEZE);
    advance();
    idle();
    #1;
    checkControl("discard_survives", C_DHIT);
    advance();

    // Data wait during load-use: full freeze for 3 cycles, bubble on the 4th.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      checkControl("dwait_freeze", C_FREEZE);
      advance();
    end
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checkControl("dwait_then_lduse", C_LDUSE);
    advance();
    checkCounters("dwait", 4, 1);

    // Halt reaching WB during a data wait.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkControl("halt_pre_dwait", C_FREEZE);
    advance();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checkControl("halt_wb", C_FREEZE);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkControl("halted_state", C_HALT);
      advance();
    end
    checkCounters("halted", 2, 0);
    // Asynchronous reset in the middle of a cycle.
    idle();
    #2;
    nRST = 1'b0;
    #1;
    checkControl("async_reset_ctl", C_RUN);
    checkCounters("async_reset", 0, 0);
    advance();
    nRST = 1'b1;

    // Saturation: 19 consecutive fetch misses with a 4-bit counter.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (i < 2) checkControl("sat_miss", C_MISS);
      advance();
      if (i == 13) checkCounters("sat_14", 14, 14);
      if (i == 15) checkCounters("sat_16", 15, 15);
    end
    checkCounters("sat_end", 15, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
